// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
//
// ID/EX pipeline stage register between decode and execute. It carries the
// EX/M/WB control bundle, both register-file read operands, the
// sign-extended immediate, the PC and the rs/rt/rd register addresses.
// The handshake on each side is valid/ready.
//
// Behaviour:
//   - The stage holds its output while execute stalls.
//   - flush turns the held and incoming instructions into a bubble.
//   - A bubble always presents ctrl_out == 0.
//   - stall_cnt is a saturating count of cycles with out_valid=1 and
//     out_ready=0.
//
// Configuration macro: ID_EX_SKID_EN
//   defined   : a one-entry skid buffer is built. in_ready is registered
//               (~skid_valid), so there is no combinational path from
//               out_ready to in_ready.
//   undefined : no skid storage. in_ready = out_ready | ~out_valid.
//   The port list is the same in both builds.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   decode-side handshake
//   ctrl_in             {EX[3:0], M[2:0], WB[1:0]} control bundle
//   rs_data_in, rt_data_in, imm_in, pc_in          DATA_W payload fields
//   rs_addr_in, rt_addr_in, rd_addr_in             ADDR_W payload fields
//   out_valid/out_ready execute-side handshake
//   *_out               registered payload towards execute
//   flush               kill held and incoming instructions
//   cnt_clr             synchronous clear of stall_cnt
//   stall_cnt           saturating stall-cycle counter
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  // decode side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] rs_data_in,
  input  logic [DATA_W-1:0] rt_data_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] rs_addr_in,
  input  logic [ADDR_W-1:0] rt_addr_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  // execute side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] rs_data_out,
  output logic [DATA_W-1:0] rt_data_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [ADDR_W-1:0] rs_addr_out,
  output logic [ADDR_W-1:0] rt_addr_out,
  output logic [ADDR_W-1:0] rd_addr_out,
  // control / status
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  // The data/address fields are packed into one vector so that the output
  // register and the skid entry share a single layout. ctrl is kept apart
  // because it is the only field that must be zeroed for a bubble.
  localparam int PAY_W = 4 * DATA_W + 3 * ADDR_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [PAY_W-1:0]  pay_in;
  logic [PAY_W-1:0]  pay_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic              valid_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;

  logic              out_free;
  logic              in_fire;

  assign pay_in = {rs_data_in, rt_data_in, imm_in, pc_in,
                   rs_addr_in, rt_addr_in, rd_addr_in};

  // The output register may take new content when execute drains it or
  // when it holds a bubble.
  assign out_free = out_ready | ~valid_reg;
  assign in_fire  = in_valid & in_ready;

`ifdef ID_EX_SKID_EN
  // -------------------------------------------------------------------------
  // Skid build: one extra entry absorbs an instruction accepted while the
  // output register is stalled. in_ready depends only on state.
  // -------------------------------------------------------------------------
  logic              skid_valid_reg;
  logic [PAY_W-1:0]  skid_pay_reg;
  logic [CTRL_W-1:0] skid_ctrl_reg;

  assign in_ready = ~skid_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg      <= 1'b0;
      ctrl_reg       <= '0;
      pay_reg        <= '0;
      skid_valid_reg <= 1'b0;
      skid_ctrl_reg  <= '0;
      skid_pay_reg   <= '0;
    end else if (flush) begin
      // Bubble the output and drop the skid entry. Any in_fire this cycle
      // is discarded. Data fields keep their last value.
      valid_reg      <= 1'b0;
      ctrl_reg       <= '0;
      skid_valid_reg <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_reg) begin
        // The older skid instruction leaves first. in_ready was 0 this
        // cycle, so no newer input can be competing for the slot.
        valid_reg      <= 1'b1;
        ctrl_reg       <= skid_ctrl_reg;
        pay_reg        <= skid_pay_reg;
        skid_valid_reg <= 1'b0;
      end else begin
        valid_reg <= in_valid;
        if (in_fire) begin
          ctrl_reg <= ctrl_in;
          pay_reg  <= pay_in;
        end else begin
          ctrl_reg <= '0;
        end
      end
    end else if (in_fire) begin
      // Output is stalled: park the incoming instruction in the skid entry.
      skid_valid_reg <= 1'b1;
      skid_ctrl_reg  <= ctrl_in;
      skid_pay_reg   <= pay_in;
    end
  end
`else
  // -------------------------------------------------------------------------
  // Plain build: acceptance follows the output register directly, so a
  // stall holds the payload exactly.
  // -------------------------------------------------------------------------
  assign in_ready = out_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
      pay_reg   <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
    end else if (out_free) begin
      valid_reg <= in_valid;
      if (in_fire) begin
        ctrl_reg <= ctrl_in;
        pay_reg  <= pay_in;
      end else begin
        ctrl_reg <= '0;
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Stall counter. cnt_clr beats the increment. flush has no effect here:
  // a flush cycle that is also a stall cycle still counts.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (cnt_clr) begin
      stall_cnt_reg <= '0;
    end else if (valid_reg && !out_ready && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Output unpacking
  // -------------------------------------------------------------------------
  assign out_valid   = valid_reg;
  assign ctrl_out    = ctrl_reg;
  assign stall_cnt   = stall_cnt_reg;

  assign rs_data_out = pay_reg[PAY_W-1          -: DATA_W];
  assign rt_data_out = pay_reg[PAY_W-1-DATA_W   -: DATA_W];
  assign imm_out     = pay_reg[PAY_W-1-2*DATA_W -: DATA_W];
  assign pc_out      = pay_reg[PAY_W-1-3*DATA_W -: DATA_W];
  assign rs_addr_out = pay_reg[3*ADDR_W-1       -: ADDR_W];
  assign rt_addr_out = pay_reg[2*ADDR_W-1       -: ADDR_W];
  assign rd_addr_out = pay_reg[ADDR_W-1         -: ADDR_W];

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CTRL_W = 9;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] ctrl_in;
  logic [DATA_W-1:0] rs_data_in, rt_data_in, imm_in, pc_in;
  logic [ADDR_W-1:0] rs_addr_in, rt_addr_in, rd_addr_in;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] rs_data_out, rt_data_out, imm_out, pc_out;
  logic [ADDR_W-1:0] rs_addr_out, rt_addr_out, rd_addr_out;
  logic              flush;
  logic              cnt_clr;
  logic [CNT_W-1:0]  stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .ctrl_in(ctrl_in),
    .rs_data_in(rs_data_in), .rt_data_in(rt_data_in),
    .imm_in(imm_in), .pc_in(pc_in),
    .rs_addr_in(rs_addr_in), .rt_addr_in(rt_addr_in), .rd_addr_in(rd_addr_in),
    .out_valid(out_valid), .out_ready(out_ready), .ctrl_out(ctrl_out),
    .rs_data_out(rs_data_out), .rt_data_out(rt_data_out),
    .imm_out(imm_out), .pc_out(pc_out),
    .rs_addr_out(rs_addr_out), .rt_addr_out(rt_addr_out), .rd_addr_out(rd_addr_out),
    .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
  );

  // Payload fields are derived from the PC so every field is checkable.
  function automatic logic [DATA_W-1:0] f_rs(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [DATA_W-1:0] f_rt(input logic [31:0] pc);
    return pc + 32'h11;
  endfunction
  function automatic logic [DATA_W-1:0] f_imm(input logic [31:0] pc);
    return ~pc;
  endfunction
  function automatic logic [CTRL_W-1:0] f_ctrl(input logic [31:0] pc);
    return pc[10:2] | 9'h001;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [CTRL_W-1:0] c);
    in_valid   = v;
    pc_in      = pc;
    ctrl_in    = c;
    rs_data_in = f_rs(pc);
    rt_data_in = f_rt(pc);
    imm_in     = f_imm(pc);
    rs_addr_in = pc[6:2];
    rt_addr_in = pc[7:3];
    rd_addr_in = pc[8:4];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, '0);
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (ctrl_out !== '0) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=0", ctrl_out); end
    n_checks++; if (pc_out !== '0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
    n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    rst = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_passthrough();
    logic [31:0] pcs [3];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i], f_ctrl(pcs[i]));
      tick();
      $display("pass-through txn pc=%h out_valid=%b pc_out=%h", pcs[i], out_valid, pc_out);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pt_valid[%0d] got=%b exp=1", i, out_valid); end
      n_checks++; if (pc_out !== pcs[i]) begin n_fail++; $display("FAIL pt_pc[%0d] got=%h exp=%h", i, pc_out, pcs[i]); end
      n_checks++; if (ctrl_out !== f_ctrl(pcs[i])) begin n_fail++; $display("FAIL pt_ctrl[%0d] got=%h exp=%h", i, ctrl_out, f_ctrl(pcs[i])); end
      n_checks++; if ({rs_data_out, rt_data_out, imm_out} !== {f_rs(pcs[i]), f_rt(pcs[i]), f_imm(pcs[i])})
        begin n_fail++; $display("FAIL pt_data[%0d] got=%h/%h/%h exp=%h/%h/%h", i, rs_data_out, rt_data_out, imm_out, f_rs(pcs[i]), f_rt(pcs[i]), f_imm(pcs[i])); end
      n_checks++; if ({rs_addr_out, rt_addr_out, rd_addr_out} !== {pcs[i][6:2], pcs[i][7:3], pcs[i][8:4]})
        begin n_fail++; $display("FAIL pt_addr[%0d] got=%h/%h/%h", i, rs_addr_out, rt_addr_out, rd_addr_out); end
    end
    drive(1'b0, 32'h10C, f_ctrl(32'h10C));
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pt_bubble_valid got=%b exp=0", out_valid); end
    n_checks++; if (ctrl_out !== '0) begin n_fail++; $display("FAIL pt_bubble_ctrl got=%h exp=0", ctrl_out); end
    n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL pt_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_stall();
    out_ready = 1'b1;
    drive(1'b1, 32'h200, f_ctrl(32'h200));
    tick();
    out_ready = 1'b0;
    drive(1'b1, 32'h204, f_ctrl(32'h204));
    #1;
`ifdef ID_EX_SKID_EN
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_in_ready_pre got=%b exp=1", in_ready); end
`else
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_pre got=%b exp=0", in_ready); end
`endif
    for (int k = 1; k <= 4; k++) begin
      tick();
      $display("stall cycle %0d pc_out=%h stall_cnt=%0d in_ready=%b", k, pc_out, stall_cnt, in_ready);
      n_checks++; if (out_valid !== 1'b1 || pc_out !== 32'h200 || ctrl_out !== f_ctrl(32'h200))
        begin n_fail++; $display("FAIL stall_hold[%0d] got v=%b pc=%h ctrl=%h exp v=1 pc=200 ctrl=%h", k, out_valid, pc_out, ctrl_out, f_ctrl(32'h200)); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", k, in_ready); end
    end
    n_checks++; if (stall_cnt !== 4'd4) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=4", stall_cnt); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b1 || pc_out !== 32'h204 || ctrl_out !== f_ctrl(32'h204))
      begin n_fail++; $display("FAIL stall_release got v=%b pc=%h exp v=1 pc=204", out_valid, pc_out); end
    n_checks++; if (stall_cnt !== 4'd4) begin n_fail++; $display("FAIL stall_cnt_after got=%0d exp=4", stall_cnt); end
    drive(1'b0, 32'h208, '0);
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_flush();
    out_ready = 1'b1;
    drive(1'b1, 32'h300, f_ctrl(32'h300));
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h304, 9'h1FF);
    tick();
    flush = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    n_checks++; if (ctrl_out !== '0) begin n_fail++; $display("FAIL flush_ctrl got=%h exp=0", ctrl_out); end
    n_checks++; if (pc_out !== 32'h300) begin n_fail++; $display("FAIL flush_data_hold got=%h exp=300", pc_out); end
    drive(1'b0, 32'h308, '0);
    tick();
    n_checks++; if (out_valid !== 1'b0 || pc_out === 32'h304) begin n_fail++; $display("FAIL flush_never_seen got v=%b pc=%h", out_valid, pc_out); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_counter();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL cnt_clear got=%0d exp=0", stall_cnt); end
    out_ready = 1'b1;
    drive(1'b1, 32'h400, f_ctrl(32'h400));
    tick();
    out_ready = 1'b0;
    drive(1'b0, 32'h404, '0);
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 10) begin
        n_checks++; if (stall_cnt !== 4'd10) begin n_fail++; $display("FAIL cnt_mid got=%0d exp=10", stall_cnt); end
      end
    end
    n_checks++; if (stall_cnt !== 4'hF) begin n_fail++; $display("FAIL cnt_saturate got=%0d exp=15", stall_cnt); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL cnt_clr_wins got=%0d exp=0", stall_cnt); end
    tick();
    n_checks++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL cnt_resume got=%0d exp=1", stall_cnt); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (stall_cnt !== 4'd2 || out_valid !== 1'b0) begin n_fail++; $display("FAIL cnt_flush got cnt=%0d v=%b exp cnt=2 v=0", stall_cnt, out_valid); end
    out_ready = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [31:0] q [$];
    logic [31:0] pc;
    logic [31:0] exp_pc;
    int sent;
    int got;
    pc = 32'h500; sent = 0; got = 0;
    for (int cyc = 0; cyc < 22; cyc++) begin
      out_ready = (cyc < 14) ? (cyc % 2 == 0) : 1'b1;
      drive(cyc < 14, pc, f_ctrl(pc));
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b2b_unexpected got pc=%h exp=none", pc_out);
        end else begin
          exp_pc = q.pop_front();
          got++;
          $display("b2b txn out pc=%h exp=%h", pc_out, exp_pc);
          n_checks++; if (pc_out !== exp_pc || ctrl_out !== f_ctrl(exp_pc))
            begin n_fail++; $display("FAIL b2b_order got pc=%h ctrl=%h exp pc=%h ctrl=%h", pc_out, ctrl_out, exp_pc, f_ctrl(exp_pc)); end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(pc);
        sent++;
        pc = pc + 32'h4;
      end
      tick();
    end
    n_checks++; if (q.size() != 0 || got != sent || sent < 7)
      begin n_fail++; $display("FAIL b2b_count got=%0d sent=%0d left=%0d", got, sent, q.size()); end
    drive(1'b0, 32'h0, '0);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_midstream();
    out_ready = 1'b1;
    drive(1'b1, 32'h600, f_ctrl(32'h600));
    tick();
    out_ready = 1'b0;
    drive(1'b1, 32'h604, f_ctrl(32'h604));
    tick();
    drive(1'b0, 32'h0, '0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || ctrl_out !== '0) begin n_fail++; $display("FAIL midrst_out got v=%b ctrl=%h exp v=0 ctrl=0", out_valid, ctrl_out); end
    n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL midrst_cnt got=%0d exp=0", stall_cnt); end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_skid_discard got v=%b pc=%h exp v=0", out_valid, pc_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_stall();
    test_flush();
    test_counter();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID/EX pipeline stage register with a valid/ready handshake, stall hold, flush-to-bubble and a saturating stall counter. It sits between the decode and execute stages. It carries the EX/M/WB control bundle, both register-file read operands, the sign-extended immediate, the PC and three register addresses. A bubble is guaranteed to present all-zero control downstream.

## Interface
Parameters:
- DATA_W, 32, width of operand, immediate and PC fields
- ADDR_W, 5, register address width
- CTRL_W, 9, control bundle width: {EX[3:0], M[2:0], WB[1:0]}
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decode presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- ctrl_in  in  CTRL_W  control bundle
- rs_data_in, rt_data_in, imm_in, pc_in  in  DATA_W  operands, immediate, PC
- rs_addr_in, rt_addr_in, rd_addr_in  in  ADDR_W  source and destination addresses
- out_valid  out  1  execute-side payload valid
- out_ready  in  1  execute accepts this cycle
- ctrl_out, rs_data_out, rt_data_out, imm_out, pc_out, rs_addr_out, rt_addr_out, rd_addr_out  out  matching  registered payload
- flush  in  1  kill all held and incoming instructions (branch or exception)
- cnt_clr  in  1  synchronous clear of stall_cnt
- stall_cnt  out  CNT_W  cycles spent with out_valid=1 and out_ready=0

## Operation
- Input fire (in_fire) = in_valid & in_ready. Output fire = out_valid & out_ready.
- The output register is free when out_ready=1 or out_valid=0.
- When the output register is free and flush=0:
  - out_valid loads in_valid.
  - The payload loads only on in_fire.
  - ctrl_out loads ctrl_in on in_fire and loads 0 otherwise.
- When the output register is not free, all outputs hold.
- Invariant: ctrl_out == 0 whenever out_valid == 0.
- When out_valid falls, the data and address fields hold their last value. Their content is don't-care.
- Flush has priority over everything except reset.
  - Next cycle: out_valid=0, ctrl_out=0, skid buffer empty.
  - Any in_fire in the flush cycle is discarded.
  - Data fields hold.
- stall_cnt:
  - Increments by 1 in each cycle where, before the edge, out_valid=1 and out_ready=0.
  - Saturates at all-ones.
  - cnt_clr forces it to 0 and wins over increment.
  - flush does not affect stall_cnt.
- Reset clears to 0: out_valid, every payload output, stall_cnt and the skid buffer. in_ready is 1 after reset in both configurations. Reset asserted mid-transfer discards everything.

## Timing
- Latency is 1 cycle from in_fire to out_valid with the payload.
- Throughput is 1 instruction per cycle when out_ready is held at 1.
- Without ID_EX_SKID_EN:
  - in_ready = out_ready | ~out_valid, which is combinational from out_ready.
  - Stall hold is exact: the payload is stable for every cycle that out_valid=1 and out_ready=0.
- With ID_EX_SKID_EN:
  - in_ready = ~skid_valid, a registered output with no combinational path from out_ready.
  - If in_fire occurs while out_valid=1 and out_ready=0, the input goes into the skid entry. skid_valid becomes 1 next cycle.
  - On the next output fire, the skid entry moves to the output register and skid_valid clears. in_ready returns to 1 one cycle later.
  - Ordering is preserved: the skid entry always leaves before any newer input.
  - Maximum occupancy is 2 instructions.
- Simultaneous output fire and in_fire with an empty skid entry: the output register loads the new input. There is no bubble.

## Configuration
- ID_EX_SKID_EN defined:
  - A one-entry skid buffer is instantiated.
  - in_ready is registered, which breaks the out_ready to in_ready timing path.
  - One extra instruction is absorbed on a stall.
- ID_EX_SKID_EN undefined:
  - No skid storage is built.
  - in_ready is combinational as stated above.
  - Area is the output register plus the counter only.
- The port list is identical in both configurations.

## Test plan
- Reset: assert rst mid-stream with out_valid=1 and the skid buffer full -> same cycle, out_valid=0, ctrl_out=0, stall_cnt=0; after release, in_ready=1.
- Pass-through: stream pc_in=0x100,0x104,0x108 with out_ready=1 -> pc_out shows the same sequence one cycle later, out_valid=1 for 3 cycles, stall_cnt=0.
- Stall: out_ready=0 for 4 cycles while holding pc_out=0x200 ->
  - payload is stable and stall_cnt=4;
  - without the skid buffer, in_ready=0 throughout;
  - with ID_EX_SKID_EN, pc=0x204 is captured into the skid entry, in_ready=0 from the next cycle, and after out_ready=1 the output shows 0x200 then 0x204.
- Flush: flush=1 with in_fire of ctrl_in=9'h1FF -> next cycle out_valid=0, ctrl_out=0, and the flushed instruction never appears at the output.
- Counter: preload near saturation by holding a stall for 2^CNT_W+3 cycles (CNT_W=4 in a bench build) -> stall_cnt stays at 0xF. cnt_clr plus stall in the same cycle -> 0.
- Simultaneous fires: in_fire and output fire every cycle, with out_ready toggling 1,0,1 -> no loss or duplication; compare against a reference queue model.
